// File: rtl/OoO_pkg.sv
//------------------------------------------------------------------------------
// Module   : OoO_pkg
// Purpose  : Shared types, defaults and helpers for the instruction fetch stage.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package OoO_pkg;

    // Default fetch geometry and reset vector.
    localparam int          FETCH_WIDTH = 2;
    localparam logic [31:0] RST_ADDR    = 32'h3000_0000;

    // One fetch block as seen by decode.
    typedef struct packed {
        logic [31:0]                  pc;
        logic [FETCH_WIDTH-1:0][31:0] inst;
        logic [FETCH_WIDTH-1:0]       lane_valid;
    } fetch_block_t;

    // Block-aligned base of a PC for a block of fetch_width 32-bit words.
    function automatic logic [31:0] block_base_of(input logic [31:0] pc,
                                                  input int unsigned fetch_width);
        logic [31:0] blk_mask;
        blk_mask = 32'(4 * fetch_width) - 32'd1;
        return pc & ~blk_mask;
    endfunction

endpackage

`default_nettype wire

// File: rtl/fetch_fifo.sv
//------------------------------------------------------------------------------
// Module   : fetch_fifo
// Purpose  : Synchronous FIFO with flush and occupancy count. Used for the
//            request tag queue and the fetch-block buffer.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module fetch_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         flush_i,
    input  logic                         push_i,
    input  logic [WIDTH-1:0]             data_i,
    input  logic                         pop_i,
    output logic [WIDTH-1:0]             data_o,
    output logic [$clog2(DEPTH+1)-1:0]   count_o
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             push_ok;
    logic             pop_ok;

    assign push_ok = push_i && (count_q != CW'(DEPTH));
    assign pop_ok  = pop_i  && (count_q != '0);
    assign data_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

    // Pointer wrap handles depths that are not a power of two.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) begin
            wr_ptr_d = (wr_ptr_q == PW'(DEPTH - 1)) ? '0 : wr_ptr_q + PW'(1);
            count_d  = count_d + CW'(1);
        end
        if (pop_ok) begin
            rd_ptr_d = (rd_ptr_q == PW'(DEPTH - 1)) ? '0 : rd_ptr_q + PW'(1);
            count_d  = count_d - CW'(1);
        end
    end

    // Pointer and count registers; a flush empties the queue in one edge.
    always_ff @(posedge clock) begin
        if (reset || flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array; contents are don't-care while the entry is unoccupied.
    always_ff @(posedge clock) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

endmodule

`default_nettype wire

// File: rtl/fetch_unit.sv
//------------------------------------------------------------------------------
// Module   : fetch_unit
// Purpose  : Instruction fetch stage: prioritised redirects, credit-limited
//            pipelined I$ requests, stale-response dropping and a block
//            buffer feeding decode with per-lane valid masks.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module fetch_unit
    import OoO_pkg::*;
#(
    parameter int          FetchWidth = FETCH_WIDTH,
    parameter int          BufDepth   = 4,
    parameter logic [31:0] RstAddr    = RST_ADDR
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        ex_valid,
    input  logic [31:0]                 mtvec_addr,
    input  logic                        mret_valid,
    input  logic [31:0]                 mepc_addr,
    input  logic                        flush_frontend,
    input  logic [31:0]                 flush_addr,
    input  logic                        bju_valid,
    input  logic                        bju_mispredict,
    input  logic [31:0]                 bju_target,
    input  logic                        replay_valid,
    input  logic [31:0]                 replay_addr,
    input  logic                        pred_valid,
    input  logic [31:0]                 pred_addr,
    output logic                        ic_req_valid,
    input  logic                        ic_req_ready,
    output logic [31:0]                 ic_req_addr,
    input  logic                        ic_rsp_valid,
    input  logic [32*FetchWidth-1:0]    ic_rsp_data,
    output logic                        dec_valid,
    input  logic                        dec_ready,
    output logic [31:0]                 dec_pc,
    output logic [32*FetchWidth-1:0]    dec_inst,
    output logic [FetchWidth-1:0]       dec_lane_valid,
    output logic                        perf_req_stall,
    output logic                        perf_rsp_drop
);

    localparam int          OFFB      = $clog2(FetchWidth) + 2;
    localparam int          LW        = (FetchWidth > 1) ? $clog2(FetchWidth) : 1;
    localparam int          CW        = $clog2(BufDepth + 1);
    localparam logic [31:0] BLK_BYTES = 32'(4 * FetchWidth);
    localparam int          TAG_W     = 32 + FetchWidth;
    localparam int          BUF_W     = 32 + 32 * FetchWidth + FetchWidth;

    logic [31:0]             pc_q, pc_d;
    logic [CW-1:0]           outstanding_q, outstanding_d;
    logic [CW-1:0]           drop_q, drop_d;

    logic                    redirect;
    logic [31:0]             redirect_addr;
    logic [31:0]             blk_base;
    logic [LW-1:0]           start_lane;
    logic [FetchWidth-1:0]   start_mask;
    logic [CW:0]             inflight;
    logic                    req_fire;
    logic                    rsp_fire;
    logic                    rsp_drop;
    logic                    buf_push;
    logic                    buf_pop;

    logic [TAG_W-1:0]        tag_rd;
    logic [CW-1:0]           tag_count;
    logic [BUF_W-1:0]        buf_rd;
    logic [CW-1:0]           buf_count;

    logic [31:0]             tag_pc;
    logic [FetchWidth-1:0]   tag_mask;
    logic [31:0]             head_pc;
    logic [32*FetchWidth-1:0] head_inst;
    logic [FetchWidth-1:0]   head_mask;

    // Redirect arbitration, highest priority first.
    always_comb begin
        redirect      = 1'b0;
        redirect_addr = '0;
        if (ex_valid) begin
            redirect      = 1'b1;
            redirect_addr = mtvec_addr;
        end else if (mret_valid) begin
            redirect      = 1'b1;
            redirect_addr = mepc_addr;
        end else if (flush_frontend) begin
            redirect      = 1'b1;
            redirect_addr = flush_addr;
        end else if (bju_valid && bju_mispredict) begin
            redirect      = 1'b1;
            redirect_addr = bju_target;
        end else if (replay_valid) begin
            redirect      = 1'b1;
            redirect_addr = replay_addr;
        end
    end

    assign blk_base = block_base_of(pc_q, FetchWidth);

    generate
        if (FetchWidth > 1) begin : g_lane_idx
            assign start_lane = pc_q[OFFB-1:2];
        end else begin : g_single_lane
            assign start_lane = '0;
        end
        for (genvar i = 0; i < FetchWidth; i++) begin : g_start_mask
            assign start_mask[i] = ((LW+1)'(i) >= {1'b0, start_lane});
        end
    endgenerate

    // Credit counts only registered state so a response always finds room.
    assign inflight     = {1'b0, outstanding_q} + {1'b0, buf_count};
    assign ic_req_valid = !reset && !redirect && (inflight < (CW+1)'(BufDepth));
    assign ic_req_addr  = ic_req_valid ? blk_base : '0;
    assign req_fire     = ic_req_valid && ic_req_ready;

    // Responses in the redirect cycle or owed to the drop counter are stale.
    assign rsp_fire = !reset && ic_rsp_valid;
    assign rsp_drop = rsp_fire && (redirect || (drop_q != '0));
    assign buf_push = rsp_fire && !rsp_drop;

    assign dec_valid = !reset && !redirect && (buf_count != '0);
    assign buf_pop   = dec_valid && dec_ready;

    assign perf_req_stall = ic_req_valid && !ic_req_ready;
    assign perf_rsp_drop  = rsp_drop;

    assign {tag_pc, tag_mask}              = tag_rd;
    assign {head_pc, head_inst, head_mask} = buf_rd;

    assign dec_pc         = dec_valid ? head_pc   : '0;
    assign dec_inst       = dec_valid ? head_inst : '0;
    assign dec_lane_valid = dec_valid ? head_mask : '0;

    // Next PC, in-flight count and stale-response debt.
    always_comb begin
        pc_d          = pc_q;
        outstanding_d = outstanding_q;
        drop_d        = drop_q;
        if (redirect) begin
            pc_d = redirect_addr;
        end else if (req_fire) begin
            pc_d = pred_valid ? pred_addr : blk_base + BLK_BYTES;
        end
        if (req_fire) begin
            outstanding_d = outstanding_d + CW'(1);
        end
        if (rsp_fire) begin
            outstanding_d = outstanding_d - CW'(1);
        end
        if (redirect) begin
            drop_d = outstanding_q - (rsp_fire ? CW'(1) : CW'(0));
        end else if (rsp_drop) begin
            drop_d = drop_q - CW'(1);
        end
    end

    // State registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            pc_q          <= RstAddr;
            outstanding_q <= '0;
            drop_q        <= '0;
        end else begin
            pc_q          <= pc_d;
            outstanding_q <= outstanding_d;
            drop_q        <= drop_d;
        end
    end

    // Start-lane tags, in request order, consumed by kept responses.
    fetch_fifo #(
        .WIDTH (TAG_W),
        .DEPTH (BufDepth)
    ) u_tag_fifo (
        .clock   (clock),
        .reset   (reset),
        .flush_i (redirect),
        .push_i  (req_fire),
        .data_i  ({pc_q, start_mask}),
        .pop_i   (buf_push),
        .data_o  (tag_rd),
        .count_o (tag_count)
    );

    // Fetch-block buffer presented to decode.
    fetch_fifo #(
        .WIDTH (BUF_W),
        .DEPTH (BufDepth)
    ) u_blk_buf (
        .clock   (clock),
        .reset   (reset),
        .flush_i (redirect),
        .push_i  (buf_push),
        .data_i  ({tag_pc, ic_rsp_data, tag_mask}),
        .pop_i   (buf_pop),
        .data_o  (buf_rd),
        .count_o (buf_count)
    );

    // Protocol checks on the I$ response stream.
    always_ff @(posedge clock) begin
        if (!reset) begin
            a_rsp_with_outstanding: assert (!(ic_rsp_valid && (outstanding_q == '0)));
            a_tag_for_kept_rsp:     assert (!(buf_push && (tag_count == '0)));
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_fetch_unit.sv
//------------------------------------------------------------------------------
// Module   : tb_fetch_unit
// Purpose  : Directed self-checking bench for fetch_unit with an I$ model of
//            programmable latency.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_fetch_unit;

    logic         clock = 1'b0;
    logic         reset = 1'b1;
    logic         ex_valid = 0, mret_valid = 0, flush_frontend = 0;
    logic         bju_valid = 0, bju_mispredict = 0, replay_valid = 0, pred_valid = 0;
    logic [31:0]  mtvec_addr = 0, mepc_addr = 0, flush_addr = 0, bju_target = 0;
    logic [31:0]  replay_addr = 0, pred_addr = 0;
    logic         ic_req_valid, ic_req_ready = 1'b1;
    logic [31:0]  ic_req_addr;
    logic         ic_rsp_valid = 1'b0;
    logic [63:0]  ic_rsp_data = '0;
    logic         dec_valid, dec_ready = 1'b1;
    logic [31:0]  dec_pc;
    logic [63:0]  dec_inst;
    logic [1:0]   dec_lane_valid;
    logic         perf_req_stall, perf_rsp_drop;

    int checks = 0;
    int errors = 0;
    int lat    = 1;
    int cyc    = 0;
    int mcyc   = 0;
    int drop_seen = 0;

    logic [31:0] ic_q_addr[$];
    int          ic_q_due[$];
    logic [31:0] req_log[$];
    int          req_cyc[$];
    logic [31:0] dpc_log[$];
    logic [1:0]  dlane_log[$];
    logic [63:0] dinst_log[$];
    int          dcyc_log[$];

    fetch_unit #(
        .FetchWidth (2),
        .BufDepth   (4),
        .RstAddr    (32'h3000_0000)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .ex_valid       (ex_valid),
        .mtvec_addr     (mtvec_addr),
        .mret_valid     (mret_valid),
        .mepc_addr      (mepc_addr),
        .flush_frontend (flush_frontend),
        .flush_addr     (flush_addr),
        .bju_valid      (bju_valid),
        .bju_mispredict (bju_mispredict),
        .bju_target     (bju_target),
        .replay_valid   (replay_valid),
        .replay_addr    (replay_addr),
        .pred_valid     (pred_valid),
        .pred_addr      (pred_addr),
        .ic_req_valid   (ic_req_valid),
        .ic_req_ready   (ic_req_ready),
        .ic_req_addr    (ic_req_addr),
        .ic_rsp_valid   (ic_rsp_valid),
        .ic_rsp_data    (ic_rsp_data),
        .dec_valid      (dec_valid),
        .dec_ready      (dec_ready),
        .dec_pc         (dec_pc),
        .dec_inst       (dec_inst),
        .dec_lane_valid (dec_lane_valid),
        .perf_req_stall (perf_req_stall),
        .perf_rsp_drop  (perf_rsp_drop)
    );

    always #5 clock = ~clock;

    // I$ model: in-order, fixed latency, lane i holds (block address + 4*i).
    initial begin
        forever begin
            @(negedge clock);
            #1;
            if (reset) begin
                ic_q_addr.delete();
                ic_q_due.delete();
                ic_rsp_valid = 1'b0;
            end else begin
                if (ic_q_addr.size() > 0 && ic_q_due[0] <= cyc) begin
                    ic_rsp_valid = 1'b1;
                    ic_rsp_data  = {ic_q_addr[0] + 32'd4, ic_q_addr[0]};
                    void'(ic_q_addr.pop_front());
                    void'(ic_q_due.pop_front());
                end else begin
                    ic_rsp_valid = 1'b0;
                end
                if (ic_req_valid && ic_req_ready) begin
                    ic_q_addr.push_back(ic_req_addr);
                    ic_q_due.push_back(cyc + lat);
                end
            end
            cyc++;
        end
    end

    // Transaction monitor: accepted requests, delivered blocks, drops.
    initial begin
        forever begin
            @(negedge clock);
            #3;
            if (reset) begin
                mcyc = 0;
            end else begin
                if (ic_req_valid && ic_req_ready) begin
                    req_log.push_back(ic_req_addr);
                    req_cyc.push_back(mcyc);
                end
                if (dec_valid && dec_ready) begin
                    dpc_log.push_back(dec_pc);
                    dlane_log.push_back(dec_lane_valid);
                    dinst_log.push_back(dec_inst);
                    dcyc_log.push_back(mcyc);
                end
                if (perf_rsp_drop) drop_seen++;
                mcyc++;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1);
    end

    function automatic logic [31:0] rq(int i);
        return (i < req_log.size()) ? req_log[i] : 32'hxxxx_xxxx;
    endfunction
    function automatic int rc(int i);
        return (i < req_cyc.size()) ? req_cyc[i] : -1;
    endfunction
    function automatic logic [31:0] dp(int i);
        return (i < dpc_log.size()) ? dpc_log[i] : 32'hxxxx_xxxx;
    endfunction
    function automatic logic [1:0] dl(int i);
        return (i < dlane_log.size()) ? dlane_log[i] : 2'bxx;
    endfunction
    function automatic logic [63:0] di(int i);
        return (i < dinst_log.size()) ? dinst_log[i] : 64'hx;
    endfunction
    function automatic int dc(int i);
        return (i < dcyc_log.size()) ? dcyc_log[i] : -1;
    endfunction

    task automatic clear_logs;
        req_log.delete(); req_cyc.delete();
        dpc_log.delete(); dlane_log.delete(); dinst_log.delete(); dcyc_log.delete();
        drop_seen = 0;
    endtask

    task automatic clear_inputs;
        ex_valid = 0; mret_valid = 0; flush_frontend = 0;
        bju_valid = 0; bju_mispredict = 0; replay_valid = 0; pred_valid = 0;
    endtask

    task automatic do_reset;
        @(negedge clock);
        reset = 1'b1;
        clear_inputs();
        ic_req_ready = 1'b1;
        dec_ready    = 1'b1;
        repeat (2) @(negedge clock);
        reset = 1'b0;
        clear_logs();
    endtask

    task automatic test_reset;
        @(negedge clock);
        reset = 1'b1;
        clear_inputs();
        ic_req_ready = 1'b0;
        dec_ready    = 1'b1;
        repeat (2) @(negedge clock);
        #2;
        checks++; if (ic_req_valid !== 1'b0) begin errors++; $display("FAIL rst_hold_req_valid: got %b expected 0", ic_req_valid); end
        checks++; if (dec_valid !== 1'b0) begin errors++; $display("FAIL rst_hold_dec_valid: got %b expected 0", dec_valid); end
        checks++; if (perf_rsp_drop !== 1'b0) begin errors++; $display("FAIL rst_hold_drop: got %b expected 0", perf_rsp_drop); end
        @(negedge clock);
        reset = 1'b0;
        clear_logs();
        #2;
        checks++; if (ic_req_valid !== 1'b1) begin errors++; $display("FAIL rst_req_valid: got %b expected 1", ic_req_valid); end
        checks++; if (ic_req_addr !== 32'h3000_0000) begin errors++; $display("FAIL rst_req_addr: got %h expected 30000000", ic_req_addr); end
        checks++; if (perf_req_stall !== 1'b1) begin errors++; $display("FAIL rst_req_stall: got %b expected 1", perf_req_stall); end
        checks++; if (dec_valid !== 1'b0) begin errors++; $display("FAIL rst_dec_valid: got %b expected 0", dec_valid); end
        checks++; if (dec_pc !== 32'h0 || dec_lane_valid !== 2'b00) begin errors++; $display("FAIL rst_dec_out: got pc=%h lanes=%b expected 0/00", dec_pc, dec_lane_valid); end
        @(negedge clock);
        ic_req_ready = 1'b1;
        #2;
        checks++; if (ic_req_addr !== 32'h3000_0000 || perf_req_stall !== 1'b0) begin errors++; $display("FAIL rst_stall_hold: got addr=%h stall=%b expected 30000000/0", ic_req_addr, perf_req_stall); end
    endtask

    task automatic test_back_to_back;
        lat = 1;
        do_reset();
        repeat (8) @(negedge clock);
        for (int i = 0; i < 3; i++) begin
            logic [31:0] a;
            a = 32'h3000_0000 + 32'(8 * i);
            checks++; if (rq(i) !== a || rc(i) !== i) begin errors++; $display("FAIL b2b_req%0d: got %h@%0d expected %h@%0d", i, rq(i), rc(i), a, i); end
            checks++; if (dp(i) !== a || dl(i) !== 2'b11 || di(i) !== {a + 32'd4, a}) begin errors++; $display("FAIL b2b_dec%0d: got pc=%h lanes=%b inst=%h expected pc=%h lanes=11 inst=%h", i, dp(i), dl(i), di(i), a, {a + 32'd4, a}); end
        end
        checks++; if (dc(0) !== 2) begin errors++; $display("FAIL b2b_dec_latency: got cycle %0d expected 2", dc(0)); end
    endtask

    task automatic test_mispredict;
        @(negedge clock);
        clear_logs();
        bju_valid = 1; bju_mispredict = 1; bju_target = 32'h3000_0104;
        #2;
        checks++; if (ic_req_valid !== 1'b0 || dec_valid !== 1'b0) begin errors++; $display("FAIL mis_redirect_cycle: got req=%b dec=%b expected 0/0", ic_req_valid, dec_valid); end
        @(negedge clock);
        clear_inputs();
        #2;
        checks++; if (ic_req_valid !== 1'b1 || ic_req_addr !== 32'h3000_0100) begin errors++; $display("FAIL mis_next_req: got %b/%h expected 1/30000100", ic_req_valid, ic_req_addr); end
        repeat (6) @(negedge clock);
        checks++; if (rq(0) !== 32'h3000_0100 || rq(1) !== 32'h3000_0108) begin errors++; $display("FAIL mis_req_seq: got %h,%h expected 30000100,30000108", rq(0), rq(1)); end
        checks++; if (dp(0) !== 32'h3000_0104 || dl(0) !== 2'b10 || di(0) !== 64'h3000_0104_3000_0100) begin errors++; $display("FAIL mis_first_block: got pc=%h lanes=%b inst=%h expected 30000104/10/3000010430000100", dp(0), dl(0), di(0)); end
        checks++; if (dp(1) !== 32'h3000_0108 || dl(1) !== 2'b11) begin errors++; $display("FAIL mis_second_block: got pc=%h lanes=%b expected 30000108/11", dp(1), dl(1)); end
        checks++; if (drop_seen !== 1) begin errors++; $display("FAIL mis_drop_count: got %0d expected 1", drop_seen); end
    endtask

    task automatic test_drop;
        lat = 4;
        do_reset();
        repeat (3) @(negedge clock);
        flush_frontend = 1; flush_addr = 32'h3000_0200;
        #2;
        checks++; if (ic_req_valid !== 1'b0) begin errors++; $display("FAIL drop_redirect_req: got %b expected 0", ic_req_valid); end
        @(negedge clock);
        clear_inputs();
        repeat (14) @(negedge clock);
        checks++; if (drop_seen !== 3) begin errors++; $display("FAIL drop_count: got %0d expected 3", drop_seen); end
        checks++; if (rq(2) !== 32'h3000_0010 || rq(3) !== 32'h3000_0200) begin errors++; $display("FAIL drop_req_seq: got %h,%h expected 30000010,30000200", rq(2), rq(3)); end
        checks++; if (dp(0) !== 32'h3000_0200 || dl(0) !== 2'b11) begin errors++; $display("FAIL drop_first_block: got pc=%h lanes=%b expected 30000200/11", dp(0), dl(0)); end
        lat = 1;
    endtask

    task automatic test_priority;
        logic [5:0]  vec [6];
        logic [31:0] exp_a [6];
        vec   = '{6'b110110, 6'b011111, 6'b001111, 6'b000111, 6'b000101, 6'b100000};
        exp_a = '{32'h3000_0400, 32'h3000_0500, 32'h3000_0600, 32'h3000_0700, 32'h3000_0800, 32'h3000_0400};
        lat = 1;
        do_reset();
        mtvec_addr = 32'h3000_0404; mepc_addr = 32'h3000_0500; flush_addr = 32'h3000_0600;
        bju_target = 32'h3000_0700; replay_addr = 32'h3000_0800;
        repeat (4) @(negedge clock);
        for (int i = 0; i < 6; i++) begin
            @(negedge clock);
            {ex_valid, mret_valid, flush_frontend, bju_valid, bju_mispredict, replay_valid} = vec[i];
            #2;
            checks++; if (ic_req_valid !== 1'b0 || dec_valid !== 1'b0) begin errors++; $display("FAIL prio%0d_redirect_cycle: got req=%b dec=%b expected 0/0", i, ic_req_valid, dec_valid); end
            @(negedge clock);
            clear_inputs();
            #2;
            checks++; if (ic_req_valid !== 1'b1 || ic_req_addr !== exp_a[i]) begin errors++; $display("FAIL prio%0d_target: got %b/%h expected 1/%h", i, ic_req_valid, ic_req_addr, exp_a[i]); end
        end
        repeat (3) @(negedge clock);
        checks++; if (dp(dpc_log.size() - 2) !== 32'h3000_0404 && dp(dpc_log.size() - 1) !== 32'h3000_0404) begin errors++; $display("FAIL prio_trap_block: got %h,%h expected 30000404", dp(dpc_log.size() - 2), dp(dpc_log.size() - 1)); end
    endtask

    task automatic test_credit;
        lat = 1;
        do_reset();
        dec_ready = 1'b0;
        repeat (8) @(negedge clock);
        #2;
        checks++; if (req_log.size() !== 4) begin errors++; $display("FAIL credit_req_count: got %0d expected 4", req_log.size()); end
        checks++; if (ic_req_valid !== 1'b0 || dec_valid !== 1'b1) begin errors++; $display("FAIL credit_full: got req=%b dec=%b expected 0/1", ic_req_valid, dec_valid); end
        @(negedge clock);
        dec_ready = 1'b1;
        @(negedge clock);
        dec_ready = 1'b0;
        repeat (5) @(negedge clock);
        #2;
        checks++; if (req_log.size() !== 5 || rq(4) !== 32'h3000_0020) begin errors++; $display("FAIL credit_refill: got count=%0d addr=%h expected 5/30000020", req_log.size(), rq(4)); end
        checks++; if (ic_req_valid !== 1'b0) begin errors++; $display("FAIL credit_refull: got %b expected 0", ic_req_valid); end
        checks++; if (dpc_log.size() !== 1 || dp(0) !== 32'h3000_0000) begin errors++; $display("FAIL credit_dequeue: got count=%0d pc=%h expected 1/30000000", dpc_log.size(), dp(0)); end
        dec_ready = 1'b1;
    endtask

    task automatic test_pred;
        lat = 1;
        do_reset();
        ic_req_ready = 1'b0;
        pred_valid = 1; pred_addr = 32'h3000_0080;
        @(negedge clock);
        ic_req_ready = 1'b1;
        pred_addr = 32'h3000_0040;
        #2;
        checks++; if (ic_req_addr !== 32'h3000_0000) begin errors++; $display("FAIL pred_ignored_unaccepted: got %h expected 30000000", ic_req_addr); end
        @(negedge clock);
        pred_valid = 0;
        #2;
        checks++; if (ic_req_valid !== 1'b1 || ic_req_addr !== 32'h3000_0040) begin errors++; $display("FAIL pred_next_req: got %b/%h expected 1/30000040", ic_req_valid, ic_req_addr); end
        repeat (6) @(negedge clock);
        checks++; if (rq(0) !== 32'h3000_0000 || rq(1) !== 32'h3000_0040 || rq(2) !== 32'h3000_0048) begin errors++; $display("FAIL pred_req_seq: got %h,%h,%h expected 30000000,30000040,30000048", rq(0), rq(1), rq(2)); end
        checks++; if (dp(0) !== 32'h3000_0000 || dp(1) !== 32'h3000_0040 || dl(1) !== 2'b11) begin errors++; $display("FAIL pred_blocks: got %h,%h lanes=%b expected 30000000,30000040/11", dp(0), dp(1), dl(1)); end
        checks++; if (drop_seen !== 0) begin errors++; $display("FAIL pred_no_flush: got %0d drops expected 0", drop_seen); end
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_mispredict();
        test_drop();
        test_priority();
        test_credit();
        test_pred();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
